// File: rtl/prcap_stream.sv
// prcap_stream: queued host requests run one four-phase empty/value handshake at a time on one of
// BLOCKWIDTH Morphle value columns. Define PRCAP_TIMEOUT_EN to add the handshake watchdog.
module prcap_stream #(
  parameter int BLOCKWIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int CW         = $clog2(BLOCKWIDTH),
  parameter int TIMEOUT    = 255
) (
  input  logic                    rconfclk,
  input  logic                    reset,
  input  logic                    cfg_we,
  input  logic [CW-1:0]           cfg_col,
  input  logic [1:0]              cfg_mode,
  input  logic [1:0]              cfg_val,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [CW-1:0]           req_col,
  input  logic                    req_bit,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [CW-1:0]           rsp_col,
  output logic [1:0]              rsp_val,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [2*BLOCKWIDTH-1:0] dout,
  input  logic [2*BLOCKWIDTH-1:0] din
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] M_STREAM = 2'b01;
  localparam logic [1:0] M_STATIC = 2'b10;

  if (BLOCKWIDTH < 2 || BLOCKWIDTH > 32 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      TIMEOUT < 1 || CW != $clog2(BLOCKWIDTH)) begin : g_bad_params
    $error("prcap_stream: unsupported parameter combination");
  end

  typedef enum logic [1:0] {IDLE, DRIVE, RELEASE, RESPOND} state_e;
  typedef logic [BLOCKWIDTH-1:0][1:0] tok_vec_t;

  state_e        state_q, state_d;
  tok_vec_t      mode_q, mode_d, sval_q, sval_d, dout_q, dout_d;
  tok_vec_t      din_s1_q, din_s2_q;
  logic [CW:0]   fifo_mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   fcnt_q, fcnt_d;
  logic          push, pop, fifo_empty, fifo_full;
  logic [CW-1:0] head_col, act_col_q, act_col_d;
  logic          head_bit, head_stream;
  logic [1:0]    tok_q, tok_d, cap_val_q, cap_val_d, col_din;
  logic          cap_err_q, cap_err_d;
  logic          rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [CW-1:0] rsp_col_q, rsp_col_d;
  logic [1:0]    rsp_val_q, rsp_val_d;
  logic          tmo;

  function automatic logic col_ok(input logic [CW-1:0] c);
    return ({1'b0, c} < (CW+1)'(BLOCKWIDTH));
  endfunction

  // Request FIFO: full blocks the host even if a pop happens in the same cycle.
  assign fifo_empty = (fcnt_q == '0);
  assign fifo_full  = (fcnt_q == (AW+1)'(DEPTH));
  assign req_ready  = !fifo_full;
  assign push       = req_valid && !fifo_full;
  assign pop        = (state_q == IDLE) && !fifo_empty && !rsp_valid_q;
  assign {head_col, head_bit} = fifo_mem_q[rptr_q];
  assign head_stream = col_ok(head_col) && (mode_q[head_col] == M_STREAM);
  assign col_din    = din_s2_q[act_col_q];

  always_comb begin
    fcnt_d = fcnt_q;
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge rconfclk) begin
    if (push) fifo_mem_q[wptr_q] <= {req_col, req_bit};
  end

`ifdef PRCAP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          in_hs;

  assign in_hs = (state_q == DRIVE) || (state_q == RELEASE);
  assign tmo   = in_hs && (tmo_cnt_q == TW'(TIMEOUT - 1));

  // Restarts whenever DRIVE or RELEASE is entered.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_d != state_q) tmo_cnt_d = '0;
    else if (in_hs)         tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge rconfclk or posedge reset) begin
    if (reset) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge rconfclk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = head_stream ? DRIVE : RESPOND;
      DRIVE:   if (col_din != 2'b00) state_d = RELEASE;
               else if (tmo)         state_d = RESPOND;
      RELEASE: if (col_din == 2'b00 || tmo) state_d = RESPOND;
      RESPOND: if (rsp_ready)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reply is staged in cap_* so the host-visible rsp_* only change when a response is posted.
  always_comb begin
    act_col_d   = act_col_q;
    tok_d       = tok_q;
    cap_val_d   = cap_val_q;
    cap_err_d   = cap_err_q;
    rsp_valid_d = rsp_valid_q;
    rsp_col_d   = rsp_col_q;
    rsp_val_d   = rsp_val_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: if (pop) begin
        act_col_d = head_col;
        tok_d     = head_bit ? 2'b10 : 2'b01;
        cap_val_d = 2'b00;
        cap_err_d = 1'b0;
        if (!head_stream) begin
          rsp_valid_d = 1'b1;
          rsp_col_d   = head_col;
          rsp_val_d   = 2'b00;
          rsp_err_d   = 1'b1;
        end
      end
      DRIVE: begin
        if (col_din != 2'b00) begin
          cap_val_d = col_din;
          cap_err_d = (col_din == 2'b11);
        end else if (tmo) begin
          rsp_valid_d = 1'b1;
          rsp_col_d   = act_col_q;
          rsp_val_d   = col_din;
          rsp_err_d   = 1'b1;
        end
      end
      RELEASE: begin
        if (col_din == 2'b00) begin
          rsp_valid_d = 1'b1;
          rsp_col_d   = act_col_q;
          rsp_val_d   = cap_val_q;
          rsp_err_d   = cap_err_q;
        end else if (tmo) begin
          rsp_valid_d = 1'b1;
          rsp_col_d   = act_col_q;
          rsp_val_d   = col_din;
          rsp_err_d   = 1'b1;
        end
      end
      RESPOND: if (rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  // The column under handshake keeps its mode until the FSM is back in IDLE.
  always_comb begin
    mode_d = mode_q;
    sval_d = sval_q;
    if (cfg_we && col_ok(cfg_col) && !(state_q != IDLE && cfg_col == act_col_q)) begin
      mode_d[cfg_col] = cfg_mode;
      sval_d[cfg_col] = cfg_val;
    end
  end

  always_comb begin
    for (int c = 0; c < BLOCKWIDTH; c++) begin
      dout_d[c] = 2'b00;
      if (mode_d[c] == M_STATIC)
        dout_d[c] = sval_d[c];
      else if (mode_d[c] == M_STREAM && state_d == DRIVE && act_col_d == CW'(c))
        dout_d[c] = tok_d;
    end
  end

  always_ff @(posedge rconfclk or posedge reset) begin
    if (reset) begin
      mode_q      <= '0;
      sval_q      <= '0;
      dout_q      <= '0;
      din_s1_q    <= '0;
      din_s2_q    <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      fcnt_q      <= '0;
      act_col_q   <= '0;
      tok_q       <= 2'b00;
      cap_val_q   <= 2'b00;
      cap_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_col_q   <= '0;
      rsp_val_q   <= 2'b00;
      rsp_err_q   <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      sval_q      <= sval_d;
      dout_q      <= dout_d;
      din_s1_q    <= din;
      din_s2_q    <= din_s1_q;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      fcnt_q      <= fcnt_d;
      act_col_q   <= act_col_d;
      tok_q       <= tok_d;
      cap_val_q   <= cap_val_d;
      cap_err_q   <= cap_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_col_q   <= rsp_col_d;
      rsp_val_q   <= rsp_val_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign dout      = dout_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_col   = rsp_col_q;
  assign rsp_val   = rsp_val_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule
